edge_binarize_clean: RTL and testbench

Stage directly downstream of the Sobel magnitude stage in the camera edge-detection chain. It thresholds the 8-bit gradient magnitude to a binary edge map and removes isolated speckle pixels with a 3x3 neighbour-count filter. It outputs a 0/max stream with the same sync format for the plotter path. It also latches a per-frame edge-pixel count for the host and control FSM.

---
 rtl/edge_binarize_clean_if.sv | 12 +
 rtl/edge_binarize_clean.sv | 144 ++++++++++++++
 tb/tb_edge_binarize_clean.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/edge_binarize_clean_if.sv
// rtl/edge_binarize_clean_if.sv - video stream bundle (syncs, pixel valid, pixel data)
interface edge_binarize_clean_if #(
  parameter int WIDTH = 8
);
  logic             vsync;
  logic             hsync;
  logic             de;
  logic [WIDTH-1:0] data;

  modport master (output vsync, output hsync, output de, output data);
  modport slave  (input  vsync, input  hsync, input  de, input  data);
endinterface

// File: rtl/edge_binarize_clean.sv
// rtl/edge_binarize_clean.sv - gradient threshold, 3x3 speckle removal, per-frame edge count
module edge_binarize_clean #(
  parameter int WIDTH      = 8,
  parameter int H_RES      = 170,
  parameter int MIN_NEIGH  = 2,
  parameter int DEFAULT_TH = 64,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  edge_binarize_clean_if.slave   vid_in,
  edge_binarize_clean_if.master  vid_out,
  input  logic [WIDTH-1:0]       i_threshold,
  output logic [CNT_W-1:0]       o_edge_count,
  output logic                   o_count_valid
);
  localparam int COL_W = $clog2(H_RES);

  logic             vsync_q;
  logic             vs_rise;
  logic [WIDTH-1:0] th_reg;
  logic [COL_W-1:0] col;
  logic [1:0]       row;
  logic             last_col;
  logic             bin_in;

  logic             lb0 [H_RES];
  logic             lb1 [H_RES];

  logic [2:0]       win_top, win_mid, win_bot;
  logic             mask1, de1;
  logic [3:0]       nsum_c, nsum;
  logic             ctr2, mask2, de2;
  logic [WIDTH-1:0] data3;
  logic             de3;
  logic [2:0]       vs_sr, hs_sr;

  logic             inc;
  logic [CNT_W-1:0] cnt, cnt_next;

  assign vs_rise  = vid_in.vsync & ~vsync_q;
  assign last_col = (col == COL_W'(H_RES - 1));
  assign bin_in   = (vid_in.data >= th_reg);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vsync_q <= 1'b0;
      th_reg  <= WIDTH'(DEFAULT_TH);
      col     <= '0;
      row     <= '0;
    end else begin
      vsync_q <= vid_in.vsync;
      if (vs_rise) begin
        th_reg <= i_threshold;
        col    <= '0;
        row    <= '0;
      end else if (vid_in.de) begin
        col <= last_col ? '0 : col + COL_W'(1);
        if (last_col && row != 2'd2)
          row <= row + 2'd1;
      end
    end
  end

  // Line buffers carry no reset; the row mask hides whatever they held.
  always_ff @(posedge clk) begin
    if (vid_in.de) begin
      lb0[col] <= bin_in;
      lb1[col] <= lb0[col];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_top <= '0;
      win_mid <= '0;
      win_bot <= '0;
      mask1   <= 1'b0;
      de1     <= 1'b0;
    end else begin
      de1 <= vid_in.de;
      if (vid_in.de) begin
        win_top <= {win_top[1:0], lb1[col]};
        win_mid <= {win_mid[1:0], lb0[col]};
        win_bot <= {win_bot[1:0], bin_in};
        mask1   <= (row < 2'd2) | (col < COL_W'(2));
      end
    end
  end

  always_comb begin
    nsum_c = '0;
    nsum_c = 4'(win_top[0]) + 4'(win_top[1]) + 4'(win_top[2])
           + 4'(win_mid[0]) + 4'(win_mid[2])
           + 4'(win_bot[0]) + 4'(win_bot[1]) + 4'(win_bot[2]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nsum  <= '0;
      ctr2  <= 1'b0;
      mask2 <= 1'b0;
      de2   <= 1'b0;
      data3 <= '0;
      de3   <= 1'b0;
      vs_sr <= '0;
      hs_sr <= '0;
    end else begin
      nsum  <= nsum_c;
      ctr2  <= win_mid[1];
      mask2 <= mask1;
      de2   <= de1;
      data3 <= (ctr2 && !mask2 && (nsum >= 4'(MIN_NEIGH))) ? {WIDTH{1'b1}} : '0;
      de3   <= de2;
      vs_sr <= {vs_sr[1:0], vid_in.vsync};
      hs_sr <= {hs_sr[1:0], vid_in.hsync};
    end
  end

  assign vid_out.data  = data3;
  assign vid_out.de    = de3;
  assign vid_out.vsync = vs_sr[2];
  assign vid_out.hsync = hs_sr[2];

  // Count the pixel leaving this cycle even when it coincides with frame start.
  assign inc      = de3 & (|data3);
  assign cnt_next = (inc && cnt != {CNT_W{1'b1}}) ? cnt + CNT_W'(1) : cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt           <= '0;
      o_edge_count  <= '0;
      o_count_valid <= 1'b0;
    end else begin
      o_count_valid <= vs_rise;
      if (vs_rise) begin
        o_edge_count <= cnt_next;
        cnt          <= '0;
      end else begin
        cnt <= cnt_next;
      end
    end
  end
endmodule

// File: tb/tb_edge_binarize_clean.sv
// tb/tb_edge_binarize_clean.sv - directed frames with a 3x3 reference model
module tb_edge_binarize_clean;
  localparam int W    = 8;
  localparam int HR   = 170;
  localparam int ROWS = 10;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [W-1:0] thr;
  logic [15:0]  edge_count;
  logic         count_valid;

  always #5 clk = ~clk;

  edge_binarize_clean_if #(.WIDTH(W)) vin ();
  edge_binarize_clean_if #(.WIDTH(W)) vout ();

  edge_binarize_clean #(
    .WIDTH(W), .H_RES(HR), .MIN_NEIGH(2), .DEFAULT_TH(64), .CNT_W(16)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .vid_in        (vin),
    .vid_out       (vout),
    .i_threshold   (thr),
    .o_edge_count  (edge_count),
    .o_count_valid (count_valid)
  );

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t_in   = 0;
  int t_out  = 0;
  bit arm_lat = 1'b0;
  bit img [ROWS][HR];
  int exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pix(input int kind, input int r, input int c);
    case (kind)
      1:       return 8'd255;
      2:       return (r == 5 && c == 50) ? 8'd200 : 8'd0;
      3:       return (r == 5 && c >= 10 && c <= 100) ? 8'd200 : 8'd0;
      4:       return 8'd100;
      5:       return 8'd64;
      default: return 8'd0;
    endcase
  endfunction

  function automatic int exp_out(input int r, input int c);
    int n;
    if (r < 2 || c < 2) return 0;
    n = 0;
    for (int dr = -2; dr <= 0; dr++)
      for (int dc = -2; dc <= 0; dc++)
        if (!(dr == -1 && dc == -1) && img[r+dr][c+dc]) n++;
    return (img[r-1][c-1] && n >= 2) ? 255 : 0;
  endfunction

  always @(negedge clk) begin
    if (vout.de) begin
      if (arm_lat) begin
        t_out   = cyc;
        arm_lat = 1'b0;
      end
      if (exp_q.size() == 0) chk("extra_out_pixel", exp_q.size(), 1);
      else                   chk("pix", vout.data, exp_q.pop_front());
    end
  end

  task automatic vs_pulse(input logic [W-1:0] th, input int exp_cnt);
    vin.vsync = 1'b1;
    thr = th;
    tick();
    chk("count_valid_hi", count_valid, 1);
    chk("edge_count", edge_count, exp_cnt);
    tick();
    chk("count_valid_lo", count_valid, 0);
    vin.vsync = 1'b0;
    tick();
    chk("o_vsync_hi", vout.vsync, 1);
    tick();
    tick();
    chk("o_vsync_lo", vout.vsync, 0);
  endtask

  task automatic run_rows(input int kind, input int th_model, input int nrows,
                          input int mid_th, input int rst_row, input bit lat);
    for (int r = 0; r < nrows; r++)
      for (int c = 0; c < HR; c++)
        img[r][c] = (int'(pix(kind, r, c)) >= th_model);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < HR; c++) begin
        if (r == rst_row && c == 80) begin
          vin.de = 1'b0;
          rstn = 1'b0;
          #1;
          chk("rst_data", vout.data, 0);
          chk("rst_de", vout.de, 0);
          chk("rst_count_valid", count_valid, 0);
          chk("rst_edge_count", edge_count, 0);
          exp_q.delete();
          tick();
          tick();
          rstn = 1'b1;
          tick();
          return;
        end
        vin.de   = 1'b1;
        vin.data = pix(kind, r, c);
        if (mid_th >= 0 && r == 5 && c == 0) thr = W'(mid_th);
        if (lat && r == 0 && c == 0) begin
          t_in    = cyc;
          arm_lat = 1'b1;
        end
        exp_q.push_back(exp_out(r, c));
        tick();
      end
      vin.de   = 1'b0;
      vin.data = '0;
      vin.hsync = 1'b1;
      repeat (3) tick();
      vin.hsync = 1'b0;
      repeat (3) tick();
    end
    repeat (4) tick();
    chk("out_queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    vin.vsync = 1'b0;
    vin.hsync = 1'b0;
    vin.de    = 1'b0;
    vin.data  = '0;
    thr       = 8'd128;
    rstn      = 1'b0;
    tick();
    tick();
    chk("reset_data", vout.data, 0);
    chk("reset_de", vout.de, 0);
    chk("reset_vsync", vout.vsync, 0);
    chk("reset_count_valid", count_valid, 0);
    chk("reset_edge_count", edge_count, 0);
    rstn = 1'b1;
    tick();

    vs_pulse(8'd128, 0);
    run_rows(0, 128, ROWS, -1, -1, 1'b0);
    vs_pulse(8'd128, 0);
    run_rows(1, 128, ROWS, -1, -1, 1'b1);
    chk("latency", t_out - t_in, 3);
    vs_pulse(8'd100, 1344);
    run_rows(2, 100, ROWS, -1, -1, 1'b0);
    vs_pulse(8'd100, 0);
    run_rows(3, 100, ROWS, -1, -1, 1'b0);
    vs_pulse(8'd255, 89);
    run_rows(4, 255, ROWS, 10, -1, 1'b0);
    vs_pulse(8'd10, 0);
    run_rows(4, 10, ROWS, -1, -1, 1'b0);
    vs_pulse(8'd128, 1344);
    run_rows(1, 128, ROWS, -1, 5, 1'b0);
    run_rows(5, 64, 4, -1, -1, 1'b0);
    vs_pulse(8'd128, 336);
    vs_pulse(8'd128, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
